// File: rtl/hasti_sram_slave_if.sv
// Hasti (AHB-lite) slave-port bundle: address/control/write data from the master,
// read data and response back; hreadyin is the bus-level ready seen by the slave.
interface hasti_sram_slave_if;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hsel;
    logic        hreadyin;
    logic        hreadyout;
    logic        hresp;

    modport master (
        output haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
        output hsel, hreadyin,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
        input  hsel, hreadyin,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/hasti_sram_slave.sv
// Word-organised SRAM behind a Hasti slave port: reads return data in the cycle after the address phase,
// stretched by WAIT_STATES low-hreadyout cycles; illegal accesses get a two-cycle ERROR and never write.
module hasti_sram_slave #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    hasti_sram_slave_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0]  WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nxt;
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          wr;
    logic [2:0]    size;

    logic          accept;
    logic          take;
    logic          addr_err;
    logic          ready_c;
    logic          resp_c;
    logic          commit;
    logic [3:0]    be;
    logic [31:0]   mem [DEPTH];

    logic          unused_inputs;
    assign unused_inputs = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0]};

    assign accept = bus.hsel & bus.hreadyin & bus.htrans[1];

    // BASE_ADDR is aligned to the array size, so the upper address bits alone decide the range.
    always_comb begin
        addr_err = 1'b0;
        if (bus.haddr[31:AW+2] != BASE_ADDR[31:AW+2]) begin
            addr_err = 1'b1;
        end
        if (bus.hsize > 3'd2) begin
            addr_err = 1'b1;
        end
        if (bus.hsize == 3'd1 && bus.haddr[0]) begin
            addr_err = 1'b1;
        end
        if (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'd0) begin
            addr_err = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready_c   = 1'b1;
        resp_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            ST_DATA: begin
                ready_c = (cnt == 4'd0);
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERR1: begin
                ready_c   = 1'b0;
                resp_c    = 1'b1;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                resp_c    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // A new address phase can only land in a cycle where this slave is completing.
        take = accept & ready_c;
        if (take) begin
            state_nxt = addr_err ? ST_ERR1 : ST_DATA;
            cnt_nxt   = WS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            idx   <= '0;
            off   <= 2'd0;
            wr    <= 1'b0;
            size  <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (take) begin
                idx  <= bus.haddr[AW+1:2];
                off  <= bus.haddr[1:0];
                wr   <= bus.hwrite;
                size <= bus.hsize;
            end
        end
    end

    always_comb begin
        be = 4'b0000;
        case (size)
            3'd0:    be[off] = 1'b1;
            3'd1:    be = off[1] ? 4'b1100 : 4'b0011;
            3'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Reset forces ST_IDLE asynchronously, so an interrupted write never reaches this edge.
    assign commit = (state == ST_DATA) && (cnt == 4'd0) && wr;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.hrdata    = (state == ST_DATA && !wr) ? mem[idx] : 32'd0;
    assign bus.hreadyout = ready_c;
    assign bus.hresp     = resp_c;
endmodule

// File: tb/tb_hasti_sram_slave.sv
// Directed bench: three slaves (0, 2 and 3 wait states) share the master-side signals
// and are selected individually; each slave's hreadyin mirrors its own hreadyout.
module tb_hasti_sram_slave;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst3_n;
    logic [31:0] m_haddr;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [1:0]  m_htrans;
    logic [31:0] m_hwdata;
    logic [2:0]  m_sel;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hasti_sram_slave_if b0 ();
    hasti_sram_slave_if b2 ();
    hasti_sram_slave_if b3 ();

    assign b0.haddr = m_haddr;  assign b0.hwrite = m_hwrite; assign b0.hsize = m_hsize;
    assign b0.htrans = m_htrans; assign b0.hwdata = m_hwdata; assign b0.hsel = m_sel[0];
    assign b0.hburst = 3'd0;    assign b0.hprot = 4'd0;      assign b0.hmastlock = 1'b0;
    assign b0.hreadyin = b0.hreadyout;

    assign b2.haddr = m_haddr;  assign b2.hwrite = m_hwrite; assign b2.hsize = m_hsize;
    assign b2.htrans = m_htrans; assign b2.hwdata = m_hwdata; assign b2.hsel = m_sel[1];
    assign b2.hburst = 3'd0;    assign b2.hprot = 4'd0;      assign b2.hmastlock = 1'b0;
    assign b2.hreadyin = b2.hreadyout;

    assign b3.haddr = m_haddr;  assign b3.hwrite = m_hwrite; assign b3.hsize = m_hsize;
    assign b3.htrans = m_htrans; assign b3.hwdata = m_hwdata; assign b3.hsel = m_sel[2];
    assign b3.hburst = 3'd0;    assign b3.hprot = 4'd0;      assign b3.hmastlock = 1'b0;
    assign b3.hreadyin = b3.hreadyout;

    hasti_sram_slave #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );
    hasti_sram_slave #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
    );
    hasti_sram_slave #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .bus(b3)
    );

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;

    // One row per clock cycle: the address phase driven this cycle, hwdata for the
    // data phase in progress, and the response expected during this cycle.
    typedef struct {
        logic        sel;
        logic [1:0]  tr;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic s, input logic [1:0] t, input logic w,
                                input logic [2:0] z, input logic [31:0] a, input logic [31:0] d,
                                input logic r, input logic e, input logic [31:0] q);
        vec_t v;
        v.sel = s; v.tr = t; v.wr = w; v.sz = z; v.addr = a; v.wdata = d;
        v.e_rdy = r; v.e_resp = e; v.e_rdata = q;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] sel, input logic [1:0] tr, input logic wr,
                         input logic [2:0] sz, input logic [31:0] addr);
        m_sel = sel; m_htrans = tr; m_hwrite = wr; m_hsize = sz; m_haddr = addr;
    endtask

    initial begin
        rst_n = 1'b1; rst3_n = 1'b1;
        drive(3'b000, T_IDLE, 1'b0, 3'd2, 32'h0);
        m_hwdata = 32'h0;
        #2;
        rst_n = 1'b0; rst3_n = 1'b0;
        #10;
        chk_bit("rst0 hreadyout", b0.hreadyout, 1'b1);
        chk_bit("rst0 hresp", b0.hresp, 1'b0);
        chk("rst0 hrdata", b0.hrdata, 32'h0);
        chk_bit("rst2 hreadyout", b2.hreadyout, 1'b1);
        chk_bit("rst3 hreadyout", b3.hreadyout, 1'b1);
        chk("rst3 hrdata", b3.hrdata, 32'h0);
        tick();
        rst_n = 1'b1; rst3_n = 1'b1;

        // Zero-wait slave: pipelined writes/reads, byte lanes, idle/deselect, errors, last word.
        tv.push_back(mk(1, T_NSEQ, 1, 2, 32'h000, 32'h0,         1, 0, 32'h0));
        tv.push_back(mk(1, T_NSEQ, 1, 2, 32'h010, 32'h55AA55AA,  1, 0, 32'h0));
        tv.push_back(mk(1, T_NSEQ, 0, 2, 32'h010, 32'hDEADBEEF,  1, 0, 32'h0));
        tv.push_back(mk(1, T_NSEQ, 1, 2, 32'h020, 32'h0,         1, 0, 32'hDEADBEEF));
        tv.push_back(mk(1, T_NSEQ, 1, 0, 32'h021, 32'h0,         1, 0, 32'h0));
        tv.push_back(mk(1, T_NSEQ, 1, 1, 32'h022, 32'h0000AA00,  1, 0, 32'h0));
        tv.push_back(mk(1, T_NSEQ, 0, 2, 32'h020, 32'h12340000,  1, 0, 32'h0));
        tv.push_back(mk(1, T_IDLE, 1, 2, 32'h020, 32'h0,         1, 0, 32'h1234AA00));
        tv.push_back(mk(0, T_NSEQ, 1, 2, 32'h020, 32'hFFFFFFFF,  1, 0, 32'h0));
        tv.push_back(mk(1, T_BUSY, 1, 2, 32'h020, 32'hFFFFFFFF,  1, 0, 32'h0));
        tv.push_back(mk(1, T_NSEQ, 0, 2, 32'h020, 32'hFFFFFFFF,  1, 0, 32'h0));
        tv.push_back(mk(1, T_NSEQ, 1, 2, 32'h012, 32'hFFFFFFFF,  1, 0, 32'h1234AA00));
        tv.push_back(mk(1, T_NSEQ, 1, 2, 32'h012, 32'hFFFFFFFF,  0, 1, 32'h0));
        tv.push_back(mk(1, T_NSEQ, 1, 1, 32'h003, 32'hFFFFFFFF,  1, 1, 32'h0));
        tv.push_back(mk(1, T_NSEQ, 1, 1, 32'h003, 32'hFFFFFFFF,  0, 1, 32'h0));
        tv.push_back(mk(1, T_NSEQ, 1, 3, 32'h010, 32'hFFFFFFFF,  1, 1, 32'h0));
        tv.push_back(mk(1, T_NSEQ, 1, 3, 32'h010, 32'hFFFFFFFF,  0, 1, 32'h0));
        tv.push_back(mk(1, T_NSEQ, 1, 2, 32'h1000, 32'hFFFFFFFF, 1, 1, 32'h0));
        tv.push_back(mk(1, T_NSEQ, 1, 2, 32'h1000, 32'hFFFFFFFF, 0, 1, 32'h0));
        tv.push_back(mk(1, T_NSEQ, 0, 2, 32'h010, 32'hFFFFFFFF,  1, 1, 32'h0));
        tv.push_back(mk(1, T_NSEQ, 0, 2, 32'h000, 32'hFFFFFFFF,  1, 0, 32'hDEADBEEF));
        tv.push_back(mk(1, T_NSEQ, 0, 2, 32'h020, 32'hFFFFFFFF,  1, 0, 32'h55AA55AA));
        tv.push_back(mk(1, T_NSEQ, 1, 2, 32'hFFC, 32'hFFFFFFFF,  1, 0, 32'h1234AA00));
        tv.push_back(mk(1, T_NSEQ, 0, 2, 32'hFFC, 32'h0BADCAFE,  1, 0, 32'h0));
        tv.push_back(mk(1, T_IDLE, 0, 2, 32'h000, 32'hFFFFFFFF,  1, 0, 32'h0BADCAFE));
        tv.push_back(mk(0, T_IDLE, 0, 2, 32'h000, 32'hFFFFFFFF,  1, 0, 32'h0));

        for (int i = 0; i < tv.size(); i++) begin
            tick();
            chk_bit($sformatf("row%0d hreadyout", i), b0.hreadyout, tv[i].e_rdy);
            chk_bit($sformatf("row%0d hresp", i), b0.hresp, tv[i].e_resp);
            chk($sformatf("row%0d hrdata", i), b0.hrdata, tv[i].e_rdata);
            drive({2'b00, tv[i].sel}, tv[i].tr, tv[i].wr, tv[i].sz, tv[i].addr);
            m_hwdata = tv[i].wdata;
        end

        // Two wait states: write then read accepted in the completing cycle.
        tick();
        drive(3'b010, T_NSEQ, 1'b1, 3'd2, 32'h10);
        tick();
        chk_bit("ws2 wr wait1", b2.hreadyout, 1'b0);
        chk_bit("ws2 wr wait1 resp", b2.hresp, 1'b0);
        drive(3'b010, T_NSEQ, 1'b0, 3'd2, 32'h10);
        m_hwdata = 32'hCAFEF00D;
        tick();
        chk_bit("ws2 wr wait2", b2.hreadyout, 1'b0);
        tick();
        chk_bit("ws2 wr done", b2.hreadyout, 1'b1);
        tick();
        chk_bit("ws2 rd wait1", b2.hreadyout, 1'b0);
        chk("ws2 rd wait1 data", b2.hrdata, 32'hCAFEF00D);
        drive(3'b010, T_IDLE, 1'b0, 3'd2, 32'h0);
        m_hwdata = 32'hFFFFFFFF;
        tick();
        chk_bit("ws2 rd wait2", b2.hreadyout, 1'b0);
        tick();
        chk_bit("ws2 rd done", b2.hreadyout, 1'b1);
        chk("ws2 rd data", b2.hrdata, 32'hCAFEF00D);
        tick();
        chk_bit("ws2 idle rdy", b2.hreadyout, 1'b1);
        chk("ws2 idle data", b2.hrdata, 32'h0);

        // Error timing is independent of the wait-state count.
        drive(3'b010, T_NSEQ, 1'b1, 3'd2, 32'h12);
        tick();
        chk_bit("ws2 err1 rdy", b2.hreadyout, 1'b0);
        chk_bit("ws2 err1 resp", b2.hresp, 1'b1);
        drive(3'b010, T_IDLE, 1'b0, 3'd2, 32'h0);
        tick();
        chk_bit("ws2 err2 rdy", b2.hreadyout, 1'b1);
        chk_bit("ws2 err2 resp", b2.hresp, 1'b1);
        tick();
        chk_bit("ws2 after err resp", b2.hresp, 1'b0);

        // Three wait states: seed 0x40, then reset in the 2nd wait cycle of an overwrite.
        drive(3'b100, T_NSEQ, 1'b1, 3'd2, 32'h40);
        tick();
        chk_bit("ws3 seed wait1", b3.hreadyout, 1'b0);
        drive(3'b100, T_NSEQ, 1'b1, 3'd2, 32'h40);
        m_hwdata = 32'h11111111;
        tick();
        tick();
        chk_bit("ws3 seed wait3", b3.hreadyout, 1'b0);
        tick();
        chk_bit("ws3 seed done", b3.hreadyout, 1'b1);
        tick();
        chk_bit("ws3 ovw wait1", b3.hreadyout, 1'b0);
        drive(3'b100, T_IDLE, 1'b0, 3'd2, 32'h0);
        m_hwdata = 32'h22222222;
        tick();
        chk_bit("ws3 ovw wait2", b3.hreadyout, 1'b0);
        #2;
        rst3_n = 1'b0;
        #1;
        chk_bit("ws3 midrst rdy", b3.hreadyout, 1'b1);
        chk_bit("ws3 midrst resp", b3.hresp, 1'b0);
        tick();
        tick();
        rst3_n = 1'b1;
        drive(3'b100, T_NSEQ, 1'b0, 3'd2, 32'h40);
        tick();
        chk_bit("ws3 rd wait1", b3.hreadyout, 1'b0);
        drive(3'b100, T_IDLE, 1'b0, 3'd2, 32'h0);
        tick();
        tick();
        tick();
        chk_bit("ws3 rd done", b3.hreadyout, 1'b1);
        chk("ws3 rd data", b3.hrdata, 32'h11111111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
